// File: rtl/cvxif_instr_pkg.sv
// Shared types and constants for the CV-X-IF LFSR coprocessor instructions.
package cvxif_instr_pkg;

   typedef enum logic [1:0] {
      LFSR_NONE = 2'd0,
      LFSR_SEED = 2'd1,
      LFSR_GEN  = 2'd2
   } lfsr_mode_t;

   // Major opcodes in the custom-0 / custom-1 spaces
   typedef enum logic [6:0] {
      FXSEED = 7'h0B,
      FXGEN  = 7'h2B
   } opcode_t;

   // Sliced down to XLEN by users; replicated so the 64-bit form matches the 32-bit one
   localparam logic [63:0] DEFAULT_SEED = 64'hACE1_ACE1_ACE1_ACE1;

endpackage

// File: rtl/cvxif_lfsr_step.sv
// Combinational Galois LFSR update: applies STEPS shift/xor steps to state_i.
module cvxif_lfsr_step #(
   parameter int unsigned     XLEN  = 32,
   parameter logic [XLEN-1:0] POLY  = XLEN'(32'hA300_0000),
   parameter int unsigned     STEPS = 1
) (
   input  logic [XLEN-1:0] state_i,
   output logic [XLEN-1:0] state_o
);

   logic [XLEN-1:0] s;

   always_comb begin
      s = state_i;
      for (int unsigned i = 0; i < STEPS; i++) begin
         if (s[0]) begin
            s = (s >> 1) ^ POLY;
         end else begin
            s = s >> 1;
         end
      end
      state_o = s;
   end

endmodule

// File: rtl/cvxif_lfsr_engine.sv
// Multi-channel LFSR engine behind a CV-X-IF style request/result handshake.
module cvxif_lfsr_engine #(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     NR_CHANNELS     = 4,
   parameter int unsigned     STEPS_PER_CYCLE = 8,
   parameter logic [XLEN-1:0] POLY            = XLEN'(32'hA300_0000),
   parameter logic [XLEN-1:0] DEFAULT_SEED    = cvxif_instr_pkg::DEFAULT_SEED[XLEN-1:0],
   parameter int unsigned     ID_WIDTH        = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  cvxif_instr_pkg::lfsr_mode_t req_mode_i,
   input  logic [3:0]                  req_chan_i,
   input  logic [XLEN-1:0]             req_seed_i,
   input  logic [ID_WIDTH-1:0]         req_id_i,
   input  logic [4:0]                  req_rd_i,
   input  logic                        flush_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [XLEN-1:0]             res_data_o,
   output logic [ID_WIDTH-1:0]         res_id_o,
   output logic [4:0]                  res_rd_o,
   output logic                        res_we_o,
   output logic                        res_err_o
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam int unsigned NumBusy = XLEN / STEPS_PER_CYCLE;
   localparam int unsigned CntW    = (NumBusy > 1) ? $clog2(NumBusy) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(NumBusy - 1);

   logic [1:0]          state_q, state_d;
   logic [XLEN-1:0]     chan_q [NR_CHANNELS];
   logic [XLEN-1:0]     chan_d [NR_CHANNELS];
   logic [XLEN-1:0]     work_q, work_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [3:0]          sel_q, sel_d;
   logic [XLEN-1:0]     res_data_q, res_data_d;
   logic [ID_WIDTH-1:0] res_id_q, res_id_d;
   logic [4:0]          res_rd_q, res_rd_d;
   logic                res_we_q, res_we_d;
   logic                res_err_q, res_err_d;

   logic [XLEN-1:0] chan_rd;
   logic [XLEN-1:0] step_out;
   logic            chan_ok;
   logic            accept;

   cvxif_lfsr_step #(
      .XLEN  (XLEN),
      .POLY  (POLY),
      .STEPS (STEPS_PER_CYCLE)
   ) u_step (
      .state_i (work_q),
      .state_o (step_out)
   );

   assign req_ready_o = (state_q == StIdle) && !rst_i;
   assign chan_ok     = 32'(req_chan_i) < NR_CHANNELS;
   assign accept      = req_valid_i && req_ready_o && !flush_i;

   always_comb begin
      chan_rd = DEFAULT_SEED;
      for (int unsigned c = 0; c < NR_CHANNELS; c++) begin
         if (req_chan_i == 4'(c)) chan_rd = chan_q[c];
      end
   end

   always_comb begin
      state_d    = state_q;
      chan_d     = chan_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_rd_d   = res_rd_q;
      res_we_d   = res_we_q;
      res_err_d  = res_err_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               res_id_d   = req_id_i;
               res_rd_d   = req_rd_i;
               res_data_d = '0;
               res_we_d   = 1'b0;
               res_err_d  = 1'b0;
               sel_d      = req_chan_i;
               cnt_d      = '0;
               if (chan_ok && req_mode_i == cvxif_instr_pkg::LFSR_GEN) begin
                  state_d = StBusy;
                  work_d  = chan_rd;
               end else if (chan_ok && req_mode_i == cvxif_instr_pkg::LFSR_SEED) begin
                  state_d = StResp;
                  for (int unsigned c = 0; c < NR_CHANNELS; c++) begin
                     if (req_chan_i == 4'(c)) begin
                        chan_d[c] = (req_seed_i == '0) ? DEFAULT_SEED : req_seed_i;
                     end
                  end
               end else begin
                  state_d   = StResp;
                  res_err_d = 1'b1;
               end
            end
         end
         StBusy: begin
            if (flush_i) begin
               state_d = StIdle;
            end else begin
               work_d = step_out;
               cnt_d  = cnt_q + CntW'(1);
               // Channel state only changes once the full word is generated
               if (cnt_q == CntLast) begin
                  state_d    = StResp;
                  cnt_d      = '0;
                  res_data_d = step_out;
                  res_we_d   = 1'b1;
                  for (int unsigned c = 0; c < NR_CHANNELS; c++) begin
                     if (sel_q == 4'(c)) chan_d[c] = step_out;
                  end
               end
            end
         end
         StResp: begin
            if (flush_i || res_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         work_q     <= '0;
         cnt_q      <= '0;
         sel_q      <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
         res_rd_q   <= '0;
         res_we_q   <= 1'b0;
         res_err_q  <= 1'b0;
         for (int unsigned c = 0; c < NR_CHANNELS; c++) chan_q[c] <= DEFAULT_SEED;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_rd_q   <= res_rd_d;
         res_we_q   <= res_we_d;
         res_err_q  <= res_err_d;
         for (int unsigned c = 0; c < NR_CHANNELS; c++) chan_q[c] <= chan_d[c];
      end
   end

   assign res_valid_o = (state_q == StResp);
   assign res_data_o  = res_data_q;
   assign res_id_o    = res_id_q;
   assign res_rd_o    = res_rd_q;
   assign res_we_o    = res_we_q;
   assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_cvxif_lfsr_engine.sv
// Scoreboard bench for cvxif_lfsr_engine: directed corner cases plus random traffic.
module tb_cvxif_lfsr_engine;
   import cvxif_instr_pkg::*;

   localparam logic [31:0] Poly = 32'hA300_0000;
   localparam logic [31:0] Dflt = 32'hACE1_ACE1;
   localparam int NumCh   = 4;
   localparam int NumBusy = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  id;
      logic [4:0]  rd;
      logic        we;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   lfsr_mode_t  req_mode_i = LFSR_NONE;
   logic [3:0]  req_chan_i = '0;
   logic [31:0] req_seed_i = '0;
   logic [2:0]  req_id_i = '0;
   logic [4:0]  req_rd_i = '0;
   logic        flush_i = 1'b0;
   logic        res_valid_o;
   logic        res_ready_i = 1'b1;
   logic [31:0] res_data_o;
   logic [2:0]  res_id_o;
   logic [4:0]  res_rd_o;
   logic        res_we_o;
   logic        res_err_o;

   int checks = 0;
   int failures = 0;
   exp_t exp_q[$];
   logic [31:0] model_ch [NumCh];
   logic [2:0]  next_id = '0;
   bit          bp_en = 1'b0;
   bit          held_v = 1'b0;
   exp_t        held;

   cvxif_lfsr_engine u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_mode_i  (req_mode_i),
      .req_chan_i  (req_chan_i),
      .req_seed_i  (req_seed_i),
      .req_id_i    (req_id_i),
      .req_rd_i    (req_rd_i),
      .flush_i     (flush_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_data_o  (res_data_o),
      .res_id_o    (res_id_o),
      .res_rd_o    (res_rd_o),
      .res_we_o    (res_we_o),
      .res_err_o   (res_err_o)
   );

   always #5 clk = ~clk;

   // Reference: n Galois steps as the plain shift/xor recurrence
   function automatic logic [31:0] lfsr_run(input logic [31:0] s, input int n);
      logic [31:0] v = s;
      for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ Poly) : (v >> 1);
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NumCh; c++) model_ch[c] = Dflt;
   endtask

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic issue(input lfsr_mode_t m, input logic [3:0] ch, input logic [31:0] sd,
                        input bit track);
      int   n = 0;
      exp_t e;
      while (!req_ready_o && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL issue_timeout got=busy want=ready");
         return;
      end
      req_valid_i = 1'b1;
      req_mode_i  = m;
      req_chan_i  = ch;
      req_seed_i  = sd;
      req_id_i    = next_id;
      req_rd_i    = 5'($urandom);
      e = '{data: '0, id: next_id, rd: req_rd_i, we: 1'b0, err: 1'b0};
      next_id++;
      if (int'(ch) >= NumCh || m == LFSR_NONE) begin
         e.err = 1'b1;
      end else if (m == LFSR_SEED) begin
         if (track) model_ch[ch] = (sd == 0) ? Dflt : sd;
      end else begin
         e.data = lfsr_run(model_ch[ch], 32);
         e.we   = 1'b1;
         if (track) model_ch[ch] = e.data;
      end
      if (track) exp_q.push_back(e);
      @(posedge clk); #2;
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready_o) && n < 500) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 500) begin
         checks++; failures++;
         $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!res_valid_o && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check("wait_valid", 64'(res_valid_o), 64'd1);
   endtask

   // Monitor: pops one expectation per completed result handshake
   always @(negedge clk) begin
      if (rst_i) begin
         held_v = 1'b0;
      end else if (res_valid_o) begin
         exp_t cur;
         cur = '{data: res_data_o, id: res_id_o, rd: res_rd_o, we: res_we_o, err: res_err_o};
         check("ready_low_in_resp", 64'(req_ready_o), 64'd0);
         if (held_v) check("held_stable", 64'(cur), 64'(held));
         if (res_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result got=%h want=none", cur);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (cur !== e) begin
                  failures++;
                  $display("FAIL result got data=%h id=%0d rd=%0d we=%b err=%b want data=%h id=%0d rd=%0d we=%b err=%b",
                           cur.data, cur.id, cur.rd, cur.we, cur.err,
                           e.data, e.id, e.rd, e.we, e.err);
               end
            end
            held_v = 1'b0;
         end else begin
            held_v = 1'b1;
            held   = cur;
         end
      end else begin
         held_v = 1'b0;
      end
   end

   always @(posedge clk) begin
      #2;
      if (bp_en) res_ready_i = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(req_ready_o), 64'd0);
      check("rst_outputs", {res_valid_o, res_data_o, res_id_o, res_rd_o, res_we_o, res_err_o},
            64'd0);
      @(posedge clk); #2;
      rst_i = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(req_ready_o), 64'd1);
      @(posedge clk); #2;

      // GEN from reset state, with BUSY latency measured
      issue(LFSR_GEN, 4'd0, '0, 1'b1);
      n = 0;
      while (!res_valid_o && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      check("gen_latency", 64'(n), 64'(NumBusy));
      drain();

      // Seed of 1 and seed of 0 (substituted)
      issue(LFSR_SEED, 4'd1, 32'h0000_0001, 1'b1);
      issue(LFSR_GEN, 4'd1, '0, 1'b1);
      issue(LFSR_SEED, 4'd2, 32'h0, 1'b1);
      issue(LFSR_GEN, 4'd2, '0, 1'b1);
      drain();

      // Flush in the second BUSY cycle: no result, no commit
      issue(LFSR_GEN, 4'd3, '0, 1'b0);
      @(posedge clk); #2;
      flush_i = 1'b1;
      @(posedge clk); #2;
      flush_i = 1'b0;
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (res_valid_o) n++;
      end
      check("flush_busy_no_valid", 64'(n), 64'd0);
      @(posedge clk); #2;
      issue(LFSR_GEN, 4'd3, '0, 1'b1);
      drain();

      // Backpressure: result held for 5 cycles
      res_ready_i = 1'b0;
      issue(LFSR_GEN, 4'd0, '0, 1'b1);
      wait_valid();
      repeat (5) begin
         @(posedge clk); #2;
      end
      check("hold_valid", 64'(res_valid_o), 64'd1);
      check("hold_pending", 64'(exp_q.size()), 64'd1);
      res_ready_i = 1'b1;
      @(posedge clk); #2;
      check("hold_released", 64'(res_valid_o), 64'd0);
      check("hold_consumed", 64'(exp_q.size()), 64'd0);

      // Out-of-range channel and NONE mode leave all channels untouched
      issue(LFSR_GEN, 4'd7, 32'h1234_5678, 1'b1);
      issue(LFSR_SEED, 4'd7, 32'h1234_5678, 1'b1);
      issue(LFSR_NONE, 4'd0, 32'h5555_5555, 1'b1);
      for (int c = 0; c < NumCh; c++) issue(LFSR_GEN, 4'(c), '0, 1'b1);
      drain();

      // Flush while a GEN result waits: result dropped, commit kept
      res_ready_i = 1'b0;
      issue(LFSR_GEN, 4'd1, '0, 1'b1);
      wait_valid();
      flush_i = 1'b1;
      @(posedge clk); #2;
      flush_i = 1'b0;
      void'(exp_q.pop_back());
      check("flush_resp_valid", 64'(res_valid_o), 64'd0);
      check("flush_resp_ready", 64'(req_ready_o), 64'd1);
      res_ready_i = 1'b1;
      issue(LFSR_GEN, 4'd1, '0, 1'b1);
      drain();

      // Flush coinciding with a request in IDLE: not accepted
      req_valid_i = 1'b1;
      req_mode_i  = LFSR_SEED;
      req_chan_i  = 4'd0;
      req_seed_i  = 32'hDEAD_BEEF;
      flush_i     = 1'b1;
      @(posedge clk); #2;
      req_valid_i = 1'b0;
      flush_i     = 1'b0;
      check("flush_idle_not_accepted", 64'(req_ready_o), 64'd1);
      issue(LFSR_GEN, 4'd0, '0, 1'b1);
      drain();

      // Reset mid-BUSY discards the op and restores default seeds
      issue(LFSR_GEN, 4'd2, '0, 1'b0);
      @(posedge clk); #2;
      rst_i = 1'b1;
      repeat (2) begin
         @(posedge clk); #2;
      end
      rst_i = 1'b0;
      model_reset();
      repeat (6) begin
         @(posedge clk); #2;
      end
      issue(LFSR_GEN, 4'd2, '0, 1'b1);
      issue(LFSR_GEN, 4'd1, '0, 1'b1);
      drain();

      // Random traffic with random result backpressure
      bp_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         lfsr_mode_t m;
         logic [31:0] sd;
         case ($urandom_range(0, 4))
            0:       m = LFSR_NONE;
            1, 2:    m = LFSR_SEED;
            default: m = LFSR_GEN;
         endcase
         sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         issue(m, 4'($urandom_range(0, 5)), sd, 1'b1);
      end
      drain();
      bp_en = 1'b0;
      @(posedge clk); #2;
      res_ready_i = 1'b1;
      for (int c = 0; c < NumCh; c++) issue(LFSR_GEN, 4'(c), '0, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cvxif_lfsr_engine.md
CVXIF_LFSR_ENGINE -- requirements
Module: cvxif_lfsr_engine

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and LFSR state width (32 or 64).
REQ-002 SHALL have parameter NR_CHANNELS, default 4, meaning number of independent LFSR states (1..16).
REQ-003 SHALL have parameter STEPS_PER_CYCLE, default 8, meaning LFSR shifts per busy cycle; it SHALL divide XLEN.
REQ-004 SHALL have parameter POLY, default XLEN'hA300_0000 (zero-extended), meaning Galois feedback polynomial.
REQ-005 SHALL have parameter DEFAULT_SEED, default XLEN'hACE1_ACE1 (replicated for 64), meaning substitute for a zero seed and reset state.
REQ-006 SHALL have parameter ID_WIDTH, default 3, meaning CV-X-IF instruction id width.
REQ-007 clk_i  in  1  clock; the block has one clock.
REQ-008 rst_i  in  1  reset; synchronous, active-high.
REQ-009 req_valid_i  in  1  request valid.
REQ-010 req_ready_o  out  1  engine can accept a request.
REQ-011 req_mode_i  in  lfsr_mode_t  NONE / LFSR_SEED / LFSR_GEN.
REQ-012 req_chan_i  in  4  channel index.
REQ-013 req_seed_i  in  XLEN  seed operand (rs1).
REQ-014 req_id_i  in  ID_WIDTH  instruction id; req_rd_i  in  5  destination register.
REQ-015 flush_i  in  1  abort any in-flight request.
REQ-016 res_valid_o  out  1, res_ready_i  in  1: result handshake.
REQ-017 res_data_o  out  XLEN; res_id_o  out  ID_WIDTH; res_rd_o  out  5; res_we_o  out  1; res_err_o  out  1.

Function
REQ-018 FSM states IDLE, BUSY, RESP; req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i & req_ready_o.
REQ-019 Step rule: lsb=s[0]; s=s>>1; if lsb then s=s^POLY; all arithmetic XLEN bits, no carry.
REQ-020 LFSR_SEED, valid channel: IDLE->RESP next cycle; channel state := req_seed_i, or DEFAULT_SEED if req_seed_i==0; res_we_o=0, res_data_o=0.
REQ-021 LFSR_GEN, valid channel: IDLE->BUSY; working copy loaded from channel; each BUSY cycle applies STEPS_PER_CYCLE steps; after XLEN/STEPS_PER_CYCLE BUSY cycles ->RESP; res_data_o=final value, res_we_o=1.
REQ-022 Channel state for GEN SHALL be committed only on the BUSY->RESP transition.
REQ-023 NONE mode or req_chan_i>=NR_CHANNELS: IDLE->RESP next cycle, no state change, res_we_o=0, res_err_o=1; otherwise res_err_o=0.
REQ-024 res_id_o/res_rd_o SHALL echo the accepted request's id/rd; result fields SHALL be held stable while res_valid_o=1 and res_ready_i=0.
REQ-025 res_valid_o=1 exactly in RESP; RESP->IDLE when res_ready_i=1; a new request SHALL NOT be accepted in that same cycle.
REQ-026 flush_i in BUSY: ->IDLE next cycle, no commit, no result; flush_i in RESP: drop result, ->IDLE; SEED state already written SHALL remain.
REQ-027 flush_i and req_valid_i in the same IDLE cycle: request SHALL NOT be accepted.

Reset
REQ-028 rst_i SHALL force IDLE, every channel state to DEFAULT_SEED, step counter to 0, res_valid_o=0, res_data_o=0, res_we_o=0, res_err_o=0, res_id_o=0, res_rd_o=0, req_ready_o=0 during reset, 1 the cycle after.
REQ-029 rst_i mid-BUSY or mid-RESP SHALL discard the operation with no result emitted.

Structure
REQ-030 lfsr_mode_t, the opcode_t values FXSEED/FXGEN, and DEFAULT_SEED constant SHALL live in cvxif_instr_pkg.
REQ-031 One combinational sub-module cvxif_lfsr_step (parameters XLEN, POLY, STEPS) SHALL implement the N-step update; the engine instantiates it twice (GEN datapath) or once shared.

Verification
REQ-032 Reset, then GEN ch0 -> result equals golden model of 32 steps from 32'hACE1ACE1, we=1, latency 4 cycles in BUSY.
REQ-033 SEED ch1 with 32'h0000_0001, then GEN ch1 with STEPS_PER_CYCLE=1 and a 1-step reference check -> first step value 32'hA300_0000.
REQ-034 SEED ch2 with 0 -> subsequent GEN ch2 matches golden run from 32'hACE1ACE1.
REQ-035 GEN ch3 with flush_i in 2nd BUSY cycle -> no res_valid_o; next GEN ch3 equals first-ever GEN result from DEFAULT_SEED.
REQ-036 GEN with res_ready_i held 0 for 5 cycles -> res_data_o/res_id_o stable, req_ready_o=0, then one result on ready.
REQ-037 req_chan_i=7 (NR_CHANNELS=4) and mode NONE -> res_err_o=1, res_we_o=0, all channel states unchanged.
